mvau_deadlock_monitor_param: RTL and testbench

//  Parametrised deadlock monitor for one MVAU HLS sub-instance. It raises `block`

---
 rtl/deadlock_mon_pkg.sv | 19 +
 rtl/dlm_lsb_encoder.sv | 20 ++
 rtl/mvau_deadlock_monitor_param.sv | 135 +++++++++++++
 tb/tb_mvau_deadlock_monitor_param.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/deadlock_mon_pkg.sv
// Shared types and helpers for the MVAU deadlock monitor.
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_BLOCK = 2'd2
  } dlm_state_t;

  localparam int DLM_SRC_W_MIN = 1;

  // Index width needed to name one of n channels, never below DLM_SRC_W_MIN.
  function automatic int dlm_src_w(input int n);
    int w;
    w = $clog2(n);
    return (w < DLM_SRC_W_MIN) ? DLM_SRC_W_MIN : w;
  endfunction

endpackage

// File: rtl/dlm_lsb_encoder.sv
// Combinational lowest-set-bit encoder with a valid flag.
module dlm_lsb_encoder #(
  parameter int W     = 5,
  parameter int IDX_W = 3
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = W - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/mvau_deadlock_monitor_param.sv
// Deadlock monitor for one MVAU sub-instance: qualifies stall flags, raises
// block after BLOCK_THRESH consecutive stall cycles, records the first
// stalling channel and counts entries into the blocked state.
module mvau_deadlock_monitor_param
  import deadlock_mon_pkg::*;
#(
  parameter int N_AXIS       = 3,
  parameter int N_INST       = 2,
  parameter int BLOCK_THRESH = 1,
  parameter int STICKY       = 0,
  parameter int CNT_W        = 8,
  parameter int SRC_W        = dlm_src_w(N_AXIS + N_INST)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  input  logic [N_AXIS-1:0] axis_mask,
  input  logic              clear,
  output logic              block,
  output logic [SRC_W-1:0]  block_src,
  output logic [CNT_W-1:0]  event_cnt
);

  localparam int Q_W   = N_AXIS + N_INST;
  localparam int RUN_W = $clog2(BLOCK_THRESH + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(BLOCK_THRESH - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Saturating increment: the event counter never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [Q_W-1:0]   q_s;
  logic [SRC_W-1:0] lsb_idx_s;
  logic             any_q_s;

  dlm_state_t       state_r;
  logic [RUN_W-1:0] run_r;
  logic             block_r;
  logic [SRC_W-1:0] src_r;
  logic [CNT_W-1:0] cnt_r;

  // Idle sub-instances never count as stalled; masked streams are ignored.
  assign q_s = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs & axis_mask};

  dlm_lsb_encoder #(
    .W     (Q_W),
    .IDX_W (SRC_W)
  ) u_lsb (
    .vec   (q_s),
    .idx   (lsb_idx_s),
    .valid (any_q_s)
  );

  // Stall-detection FSM with run counter, source capture and event counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= S_IDLE;
      run_r   <= '0;
      block_r <= 1'b0;
      src_r   <= '0;
      cnt_r   <= '0;
    end else if (clear) begin
      // Clear restarts detection but keeps the event history.
      state_r <= S_IDLE;
      run_r   <= '0;
      block_r <= 1'b0;
      src_r   <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (any_q_s) begin
            src_r <= lsb_idx_s;
            if (BLOCK_THRESH == 1) begin
              state_r <= S_BLOCK;
              run_r   <= '0;
              block_r <= 1'b1;
              cnt_r   <= sat_inc(cnt_r);
            end else begin
              state_r <= S_PEND;
              run_r   <= RUN_ONE;
              block_r <= 1'b0;
            end
          end else begin
            state_r <= S_IDLE;
            run_r   <= '0;
            block_r <= 1'b0;
          end
        end
        S_PEND: begin
          if (!any_q_s) begin
            state_r <= S_IDLE;
            run_r   <= '0;
            block_r <= 1'b0;
          end else if (run_r == RUN_LAST) begin
            state_r <= S_BLOCK;
            run_r   <= '0;
            block_r <= 1'b1;
            cnt_r   <= sat_inc(cnt_r);
          end else begin
            state_r <= S_PEND;
            run_r   <= run_r + RUN_W'(1);
            block_r <= 1'b0;
          end
        end
        S_BLOCK: begin
          if ((STICKY == 0) && !any_q_s) begin
            state_r <= S_IDLE;
            run_r   <= '0;
            block_r <= 1'b0;
          end else begin
            state_r <= S_BLOCK;
            run_r   <= '0;
            block_r <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          run_r   <= '0;
          block_r <= 1'b0;
          src_r   <= '0;
        end
      endcase
    end
  end

  assign block     = block_r;
  assign block_src = src_r;
  assign event_cnt = cnt_r;

endmodule

// File: tb/tb_mvau_deadlock_monitor_param.sv
// Scoreboard bench: four monitor configurations share one stimulus stream;
// a behavioural streak model pushes expected outputs, compared after each edge.
module tb_mvau_deadlock_monitor_param;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] axis_block_sigs;
  logic [1:0] inst_idle_sigs;
  logic [1:0] inst_block_sigs;
  logic [2:0] axis_mask;
  logic       clear;

  logic       blk0, blk1, blk2, blk3;
  logic [2:0] src0, src1, src2, src3;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  always #5 clock = ~clock;

  mvau_deadlock_monitor_param #(.BLOCK_THRESH(1), .STICKY(0), .CNT_W(8)) u_t1 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .axis_mask(axis_mask), .clear(clear),
    .block(blk0), .block_src(src0), .event_cnt(cnt0));

  mvau_deadlock_monitor_param #(.BLOCK_THRESH(4), .STICKY(0), .CNT_W(8)) u_t4 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .axis_mask(axis_mask), .clear(clear),
    .block(blk1), .block_src(src1), .event_cnt(cnt1));

  mvau_deadlock_monitor_param #(.BLOCK_THRESH(1), .STICKY(1), .CNT_W(8)) u_st (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .axis_mask(axis_mask), .clear(clear),
    .block(blk2), .block_src(src2), .event_cnt(cnt2));

  mvau_deadlock_monitor_param #(.BLOCK_THRESH(3), .STICKY(0), .CNT_W(2)) u_c2 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .axis_mask(axis_mask), .clear(clear),
    .block(blk3), .block_src(src3), .event_cnt(cnt3));

  typedef struct {
    int k;
    int blk;
    int src;
    int cnt;
  } exp_t;

  exp_t exp_q[$];

  int thr[4]  = '{1, 4, 1, 3};
  int stk[4]  = '{0, 0, 1, 0};
  int cmax[4] = '{255, 255, 255, 3};

  int m_streak[4];
  int m_blk[4];
  int m_src[4];
  int m_cnt[4];

  int n_tests = 0;
  int n_fail  = 0;

  // Count one comparison and report it when observed differs from expected.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_blk(input int k);
    case (k)
      0: return int'(blk0);
      1: return int'(blk1);
      2: return int'(blk2);
      default: return int'(blk3);
    endcase
  endfunction

  function automatic int dut_src(input int k);
    case (k)
      0: return int'(src0);
      1: return int'(src1);
      2: return int'(src2);
      default: return int'(src3);
    endcase
  endfunction

  function automatic int dut_cnt(input int k);
    case (k)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  // Streak model: block follows the count of consecutive qualified-stall cycles.
  task automatic model_step(input int k, input logic [2:0] ab, input logic [1:0] ii,
                            input logic [1:0] ib, input logic [2:0] mk,
                            input logic clr, input logic rst);
    logic [4:0] q;
    int low;
    q = {ib & ~ii, ab & mk};
    low = -1;
    for (int i = 4; i >= 0; i--) if (q[i]) low = i;
    if (!rst) begin
      m_streak[k] = 0; m_blk[k] = 0; m_src[k] = 0; m_cnt[k] = 0;
    end else if (clr) begin
      m_streak[k] = 0; m_blk[k] = 0; m_src[k] = 0;
    end else if (stk[k] == 1 && m_blk[k] == 1) begin
      m_streak[k] = 0;
    end else if (low < 0) begin
      m_streak[k] = 0; m_blk[k] = 0;
    end else begin
      if (m_streak[k] == 0) m_src[k] = low;
      m_streak[k]++;
      if (m_blk[k] == 0 && m_streak[k] >= thr[k]) begin
        m_blk[k] = 1;
        if (m_cnt[k] < cmax[k]) m_cnt[k]++;
      end
    end
  endtask

  // Drive one cycle, push expectations, then check all four monitors after the edge.
  task automatic step(input logic [2:0] ab, input logic [1:0] ii, input logic [1:0] ib,
                      input logic [2:0] mk, input logic clr, input logic rst);
    exp_t e;
    axis_block_sigs = ab;
    inst_idle_sigs  = ii;
    inst_block_sigs = ib;
    axis_mask       = mk;
    clear           = clr;
    reset           = rst;
    for (int k = 0; k < 4; k++) begin
      model_step(k, ab, ii, ib, mk, clr, rst);
      e.k = k; e.blk = m_blk[k]; e.src = m_src[k]; e.cnt = m_cnt[k];
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("blk%0d", e.k), dut_blk(e.k), e.blk);
      check_eq($sformatf("src%0d", e.k), dut_src(e.k), e.src);
      check_eq($sformatf("cnt%0d", e.k), dut_cnt(e.k), e.cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 2'b00, 2'b00, 3'b111, 1'b0, 1'b1);
  endtask

  initial begin
    int snap;
    // reset
    step(3'b000, 2'b00, 2'b00, 3'b111, 1'b0, 1'b0);
    step(3'b101, 2'b00, 2'b11, 3'b111, 1'b1, 1'b0);
    check_eq("rst_blk", blk0, 0);
    check_eq("rst_cnt", cnt0, 0);
    idle(2);

    // 1: single-cycle stall on stream 2, threshold 1
    step(3'b100, 2'b00, 2'b00, 3'b111, 1'b0, 1'b1);
    check_eq("t1_blk", blk0, 1);
    check_eq("t1_src", src0, 2);
    check_eq("t1_cnt", cnt0, 1);
    idle(1);
    check_eq("t1_drop", blk0, 0);
    idle(1);

    // 2: threshold 4, broken run then full run
    for (int i = 0; i < 3; i++) step(3'b001, 2'b00, 2'b00, 3'b111, 1'b0, 1'b1);
    check_eq("t2_run1", blk1, 0);
    idle(1);
    for (int i = 0; i < 3; i++) step(3'b001, 2'b00, 2'b00, 3'b111, 1'b0, 1'b1);
    check_eq("t2_early", blk1, 0);
    step(3'b001, 2'b00, 2'b00, 3'b111, 1'b0, 1'b1);
    check_eq("t2_blk", blk1, 1);
    check_eq("t2_cnt", cnt1, 1);
    idle(2);

    // 3: idle sub-instance never stalls; dropping idle does
    for (int i = 0; i < 4; i++) step(3'b000, 2'b01, 2'b01, 3'b111, 1'b0, 1'b1);
    check_eq("t3_noblk", blk0, 0);
    step(3'b000, 2'b00, 2'b01, 3'b111, 1'b0, 1'b1);
    check_eq("t3_blk", blk0, 1);
    check_eq("t3_src", src0, 3);
    idle(2);

    // 4: sticky block holds until clear, counter kept
    step(3'b000, 2'b00, 2'b00, 3'b111, 1'b1, 1'b1);
    step(3'b010, 2'b00, 2'b00, 3'b111, 1'b0, 1'b1);
    idle(3);
    check_eq("t4_hold", blk2, 1);
    snap = m_cnt[2];
    step(3'b000, 2'b00, 2'b00, 3'b111, 1'b1, 1'b1);
    check_eq("t4_clr", blk2, 0);
    check_eq("t4_cnt", cnt2, snap);
    idle(1);

    // 5: counter saturation at CNT_W=2, then reset mid-pending
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 3; i++) step(3'b010, 2'b00, 2'b00, 3'b111, 1'b0, 1'b1);
      idle(1);
    end
    check_eq("t5_sat", cnt3, 3);
    step(3'b010, 2'b00, 2'b00, 3'b111, 1'b0, 1'b1);
    step(3'b010, 2'b00, 2'b00, 3'b111, 1'b0, 1'b0);
    check_eq("t5_rblk", blk3, 0);
    check_eq("t5_rsrc", src3, 0);
    check_eq("t5_rcnt", cnt3, 0);
    idle(1);

    // 6: masking, mask during pending, clear colliding with stall
    for (int i = 0; i < 3; i++) step(3'b100, 2'b00, 2'b00, 3'b011, 1'b0, 1'b1);
    check_eq("t6_mask", blk0, 0);
    step(3'b001, 2'b00, 2'b00, 3'b111, 1'b0, 1'b1);
    step(3'b001, 2'b00, 2'b00, 3'b110, 1'b0, 1'b1);
    check_eq("t6_mpend", blk0, 0);
    step(3'b100, 2'b00, 2'b00, 3'b111, 1'b1, 1'b1);
    check_eq("t6_clrwin", blk0, 0);
    step(3'b100, 2'b00, 2'b00, 3'b111, 1'b0, 1'b1);
    check_eq("t6_restart", blk0, 1);
    check_eq("t6_pend", blk1, 0);
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
